dm_store_buf: RTL and testbench

- Store buffer directly upstream of the 4 KB data memory.
- Accepts byte and word stores from the MEM stage into a small FIFO, so a store never stalls the pipeline on a busy memory port.
- Drains one entry per cycle into the data memory's write port whenever that port is free.
- Flags loads that target a word with a pending store; the hazard unit stalls on that flag until the word drains.

---
 rtl/dm_pkg.sv | 17 +
 rtl/sb_entry_array.sv | 30 +++
 rtl/dm_store_buf.sv | 87 ++++++++
 tb/tb_dm_store_buf.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared opcodes and the store-buffer entry layout.
package dm_pkg;
  localparam int SB_AW = 12;
  localparam int SB_DW = 32;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  // One buffered store, kept exactly as the MEM stage presented it.
  typedef struct packed {
    logic [5:0]       op;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_entry_array.sv
// DEPTH-entry register file for buffered stores: one write port, one read
// port, plus every slot's address exposed for the load-hazard compare.
module sb_entry_array
  import dm_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [PTR_W-1:0]            wr_idx,
  input  sb_entry_t                   wr_entry,
  input  logic [PTR_W-1:0]            rd_idx,
  output sb_entry_t                   rd_entry,
  output logic [DEPTH-1:0][SB_AW-1:0] addrs
);

  sb_entry_t mem [DEPTH];

  // Slot contents need no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_entry;
  end

  assign rd_entry = mem[rd_idx];

  for (genvar g = 0; g < DEPTH; g++) begin : g_addr
    assign addrs[g] = mem[g].addr;
  end
endmodule

// File: rtl/dm_store_buf.sv
// Store buffer in front of the data memory: FIFO of stores, drained one per
// free write-port cycle, with a word-granular load hazard over pending stores.
module dm_store_buf
  import dm_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = SB_AW,
  parameter  int DW    = SB_DW,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  input  logic [5:0]       st_op,
  input  logic [AW-1:0]    st_addr,
  input  logic [DW-1:0]    st_data,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  output logic             ld_hazard,
  input  logic             dm_port_free,
  output logic             dm_WrEn,
  output logic [5:0]       dm_op,
  output logic [AW-1:0]    dm_Addr,
  output logic [DW-1:0]    dm_DataIn,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count
);

  logic [PTR_W-1:0]            rd_ptr, wr_ptr;
  logic [PTR_W:0]              count;
  logic                        push, pop, hit;
  logic [PTR_W-1:0]            off;
  sb_entry_t                   wr_entry, rd_entry;
  logic [DEPTH-1:0][SB_AW-1:0] addrs;

  assign st_ready = (count != (PTR_W+1)'(DEPTH));
  assign sb_empty = (count == '0);
  assign sb_count = count;

  // Full blocks the push and empty blocks the pop, so no bypass path exists.
  assign push    = st_valid && st_ready;
  assign pop     = dm_WrEn;
  assign dm_WrEn = !sb_empty && dm_port_free;

  assign wr_entry  = '{op: st_op, addr: st_addr, data: st_data};
  assign dm_op     = rd_entry.op;
  assign dm_Addr   = rd_entry.addr;
  assign dm_DataIn = rd_entry.data;

  sb_entry_array #(.DEPTH(DEPTH)) u_array (
    .clk      (clk),
    .wr_en    (push),
    .wr_idx   (wr_ptr),
    .wr_entry (wr_entry),
    .rd_idx   (rd_ptr),
    .rd_entry (rd_entry),
    .addrs    (addrs)
  );

  // Pointer and occupancy update; reset discards everything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Word compare against occupied slots only (distance from head < count),
  // so freed slots with stale addresses never raise a hazard.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (({1'b0, off} < count) && (addrs[i][AW-1:2] == ld_addr[AW-1:2]))
        hit = 1'b1;
    end
  end

  assign ld_hazard = ld_valid && hit;
endmodule

// File: tb/tb_dm_store_buf.sv
module tb_dm_store_buf;
  localparam int DEPTH = 4;
  localparam logic [5:0] SB = 6'b101000, SW = 6'b101011;

  logic        clk = 0, rst_n = 0;
  logic        st_valid = 0, ld_valid = 0, dm_port_free = 0;
  logic [5:0]  st_op = 0;
  logic [11:0] st_addr = 0, ld_addr = 0;
  logic [31:0] st_data = 0;
  logic        st_ready, ld_hazard, dm_WrEn, sb_empty;
  logic [5:0]  dm_op;
  logic [11:0] dm_Addr;
  logic [31:0] dm_DataIn;
  logic [2:0]  sb_count;

  dm_store_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dm_port_free(dm_port_free), .dm_WrEn(dm_WrEn), .dm_op(dm_op),
    .dm_Addr(dm_Addr), .dm_DataIn(dm_DataIn), .sb_empty(sb_empty),
    .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] op; logic [11:0] addr; logic [31:0] data; } st_t;
  st_t         q[$];
  logic [11:0] log_q[$];
  int          tests = 0, fails = 0;
  logic        obs_haz, obs_wr, obs_ready, obs_empty;
  logic [5:0]  obs_op;
  logic [11:0] obs_addr;
  logic [31:0] obs_data;
  logic [2:0]  obs_cnt;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: drive, check every output against the queue model at negedge,
  // then apply the pop/push the model says happens at the posedge.
  task automatic cyc(input logic sv, input logic [5:0] op, input logic [11:0] a,
                     input logic [31:0] d, input logic lv, input logic [11:0] la,
                     input logic pf);
    logic e_haz, e_wr, do_push;
    st_valid = sv; st_op = op; st_addr = a; st_data = d;
    ld_valid = lv; ld_addr = la; dm_port_free = pf;
    @(negedge clk);
    e_haz = 0;
    if (lv) foreach (q[i]) if (q[i].addr[11:2] == la[11:2]) e_haz = 1;
    e_wr = (q.size() > 0) && pf;
    chk("sb_count", sb_count, q.size());
    chk("st_ready", st_ready, q.size() < DEPTH);
    chk("sb_empty", sb_empty, q.size() == 0);
    chk("ld_hazard", ld_hazard, e_haz);
    chk("dm_WrEn", dm_WrEn, e_wr);
    if (e_wr) begin
      chk("dm_op", dm_op, q[0].op);
      chk("dm_Addr", dm_Addr, q[0].addr);
      chk("dm_DataIn", dm_DataIn, q[0].data);
    end
    if (dm_WrEn) log_q.push_back(dm_Addr);
    obs_haz = ld_hazard; obs_wr = dm_WrEn; obs_ready = st_ready; obs_empty = sb_empty;
    obs_op = dm_op; obs_addr = dm_Addr; obs_data = dm_DataIn; obs_cnt = sb_count;
    do_push = sv && (q.size() < DEPTH);
    @(posedge clk);
    if (e_wr) void'(q.pop_front());
    if (do_push) q.push_back('{op, a, d});
    #1;
  endtask

  task automatic idle(input logic pf);
    cyc(0, 6'd0, 12'd0, 32'd0, 0, 12'd0, pf);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_wren", dm_WrEn, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", sb_empty, 1);
    chk("rst_count", sb_count, 0);
    @(posedge clk); #1 rst_n = 1;

    // 1: single sw, held by a busy port, then drained
    cyc(1, SW, 12'h004, 32'h12345678, 0, 0, 0);
    idle(0);
    chk("t1_cnt", obs_cnt, 1);
    chk("t1_wr_held", obs_wr, 0);
    idle(1);
    chk("t1_wr", obs_wr, 1);
    chk("t1_addr", obs_addr, 12'h004);
    chk("t1_data", obs_data, 32'h12345678);
    chk("t1_op", obs_op, SW);
    idle(0);
    chk("t1_empty", obs_empty, 1);

    // 2: fill, ignored fifth store, drain order
    for (int i = 0; i < 4; i++) cyc(1, SW, 12'(i * 4), 32'(i + 100), 0, 0, 0);
    cyc(1, SW, 12'h010, 32'hBAD, 0, 0, 0);
    chk("t2_ready", obs_ready, 0);
    chk("t2_cnt", obs_cnt, 4);
    log_q.delete();
    for (int i = 0; i < 5; i++) idle(1);
    chk("t2_nlog", log_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < log_q.size()) chk("t2_order", log_q[i], 12'(i * 4));

    // 3: word-granular load hazard
    cyc(1, SB, 12'h00D, 32'h55, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 12'h00C, 0);
    chk("t3_haz_same_word", obs_haz, 1);
    cyc(0, 0, 0, 0, 1, 12'h010, 0);
    chk("t3_haz_other_word", obs_haz, 0);
    cyc(0, 0, 0, 0, 1, 12'h00C, 1);
    chk("t3_haz_during_pop", obs_haz, 1);
    cyc(0, 0, 0, 0, 1, 12'h00C, 0);
    chk("t3_haz_after_pop", obs_haz, 0);

    // 4: simultaneous push/pop keeps count; order preserved across wrap
    cyc(1, SW, 12'h100, 32'h1, 0, 0, 0);
    cyc(1, SW, 12'h104, 32'h2, 0, 0, 0);
    log_q.delete();
    cyc(1, SW, 12'h020, 32'h3, 0, 0, 1);
    idle(0);
    chk("t4_cnt", obs_cnt, 2);
    idle(1); idle(1);
    chk("t4_nlog", log_q.size(), 3);
    if (log_q.size() == 3) chk("t4_third", log_q[2], 12'h020);
    for (int i = 0; i < DEPTH + 2; i++) cyc(1, SW, 12'(12'h200 + i * 4), 32'(i), 0, 0, 1);
    for (int i = 0; i < 3; i++) idle(1);

    // 6: sb then sw to the same byte address, drained unmodified
    cyc(1, SB, 12'h003, 32'h000000AB, 0, 0, 0);
    cyc(1, SW, 12'h003, 32'hDEADBEEF, 0, 0, 0);
    idle(1);
    chk("t6_op_sb", obs_op, SB);
    chk("t6_addr_sb", obs_addr, 12'h003);
    chk("t6_data_sb", obs_data, 32'h000000AB);
    idle(1);
    chk("t6_op_sw", obs_op, SW);
    chk("t6_addr_sw", obs_addr, 12'h003);
    chk("t6_data_sw", obs_data, 32'hDEADBEEF);

    // 5: async reset mid-drain
    cyc(1, SW, 12'h040, 32'h9, 0, 0, 0);
    cyc(1, SW, 12'h044, 32'hA, 0, 0, 0);
    st_valid = 0; dm_port_free = 1;
    #2;
    chk("t5_wr_before", dm_WrEn, 1);
    rst_n = 0;
    #1;
    chk("t5_wr_async", dm_WrEn, 0);
    chk("t5_cnt_async", sb_count, 0);
    chk("t5_empty_async", sb_empty, 1);
    q.delete();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 12'(12'h040 + i * 4), 0);
      chk("t5_haz_clear", obs_haz, 0);
    end

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic sv, lv;
      logic [5:0] op;
      sv = ($urandom_range(0, 99) < 55);
      lv = !sv && $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: op = SB;
        1: op = SW;
        default: op = 6'($urandom);
      endcase
      cyc(sv, op, 12'($urandom_range(0, 63)), $urandom, lv,
          12'($urandom_range(0, 63)), ($urandom_range(0, 99) < 45));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
